// File: rtl/cache_tag_pkg.sv
// cache_tag_pkg: shared geometry, tag-word bit positions and FSM states
// for the tag lookup block.
`default_nettype none

package cache_tag_pkg;

  localparam int AWIDTH    = 3;
  localparam int TAG_W     = 12;
  localparam int OFF_W     = 2;
  localparam int DWIDTH    = TAG_W + 2;
  localparam int VALID_BIT = DWIDTH - 1;
  localparam int DIRTY_BIT = DWIDTH - 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_COMPARE = 3'd2,
    S_UPDATE  = 3'd3,
    S_RESP    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones.
`default_nettype none

module sat_counter16 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 16'h0000;
    end else if (inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'h0001;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/tag_hit_check.sv
// tag_hit_check: single-request tag lookup against an external synchronous
// tag RAM, with allocate-on-miss, dirty tracking and hit/miss statistics.
`default_nettype none

module tag_hit_check #(
  parameter int  AWIDTH = cache_tag_pkg::AWIDTH,
  parameter int  TAG_W  = cache_tag_pkg::TAG_W,
  parameter int  OFF_W  = cache_tag_pkg::OFF_W,
  localparam int DWIDTH = TAG_W + 2,
  localparam int ADDR_W = TAG_W + AWIDTH + OFF_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_evict,
  output logic [TAG_W-1:0]  rsp_victim_tag,
  output logic [AWIDTH-1:0] tram_addr,
  output logic              tram_we,
  output logic [DWIDTH-1:0] tram_din,
  input  logic [DWIDTH-1:0] tram_dout,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  import cache_tag_pkg::*;

  state_t              r_state;
  logic                r_req_ready;
  logic [TAG_W-1:0]    r_tag;
  logic [AWIDTH-1:0]   r_index;
  logic                r_write;
  logic                r_tram_we;
  logic [DWIDTH-1:0]   r_tram_din;
  logic                r_rsp_valid;
  logic                r_rsp_hit;
  logic                r_rsp_evict;
  logic [TAG_W-1:0]    r_victim_tag;

  logic                w_valid;
  logic                w_dirty;
  logic [TAG_W-1:0]    w_stored_tag;
  logic                w_hit;
  logic                w_evict;
  logic                w_need_update;
  logic                w_in_compare;
  logic                w_unused_offset;

  assign w_valid         = tram_dout[DWIDTH-1];
  assign w_dirty         = tram_dout[DWIDTH-2];
  assign w_stored_tag    = tram_dout[TAG_W-1:0];
  assign w_hit           = w_valid && (w_stored_tag == r_tag);
  assign w_evict         = !w_hit && w_valid && w_dirty;
  // A dirty write hit already has the right word stored; only clean write
  // hits and every miss need to touch the RAM.
  assign w_need_update   = !w_hit || (r_write && !w_dirty);
  assign w_in_compare    = (r_state == S_COMPARE);
  assign w_unused_offset = ^req_addr[OFF_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_tag        <= '0;
      r_index      <= '0;
      r_write      <= 1'b0;
      r_tram_we    <= 1'b0;
      r_tram_din   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_evict  <= 1'b0;
      r_victim_tag <= '0;
    end else begin
      r_tram_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_tag       <= req_addr[ADDR_W-1 -: TAG_W];
            r_index     <= req_addr[OFF_W +: AWIDTH];
            r_write     <= req_write;
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          r_rsp_hit    <= w_hit;
          r_rsp_evict  <= w_evict;
          r_victim_tag <= w_evict ? w_stored_tag : '0;
          if (w_need_update) begin
            r_tram_we  <= 1'b1;
            r_tram_din <= {1'b1, r_write, r_tag};
            r_state    <= S_UPDATE;
          end else begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_UPDATE: begin
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  sat_counter16 u_hit_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_in_compare && w_hit),
    .count   (hit_count)
  );

  sat_counter16 u_miss_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_in_compare && !w_hit),
    .count   (miss_count)
  );

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_hit        = r_rsp_hit;
  assign rsp_evict      = r_rsp_evict;
  assign rsp_victim_tag = r_victim_tag;
  assign tram_addr      = r_index;
  assign tram_we        = r_tram_we;
  assign tram_din       = r_tram_din;

endmodule

`default_nettype wire

// File: tb/tb_tag_hit_check.sv
// tb_tag_hit_check: drives tag lookups against a behavioural tag RAM and
// checks responses, RAM writes, latency and counters against a reference model.
`default_nettype none

module tb_tag_hit_check;

  localparam int AW  = 3;
  localparam int TW  = 12;
  localparam int OW  = 2;
  localparam int DW  = TW + 2;
  localparam int ADW = TW + AW + OW;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           req_valid;
  logic           req_ready;
  logic [ADW-1:0] req_addr;
  logic           req_write;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_hit;
  logic           rsp_evict;
  logic [TW-1:0]  rsp_victim_tag;
  logic [AW-1:0]  tram_addr;
  logic           tram_we;
  logic [DW-1:0]  tram_din;
  logic [DW-1:0]  tram_dout;
  logic [15:0]    hit_count;
  logic [15:0]    miss_count;

  logic [DW-1:0]  mem     [8];
  logic [DW-1:0]  ref_mem [8];
  int             model_hits;
  int             model_misses;
  int             errors;
  int             checks;

  always #5 clock = ~clock;

  // Synchronous tag RAM: data for the address sampled at an edge appears after it.
  always @(posedge clock) begin
    tram_dout <= mem[tram_addr];
    if (tram_we) mem[tram_addr] <= tram_din;
  end

  tag_hit_check dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_write      (req_write),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_hit        (rsp_hit),
    .rsp_evict      (rsp_evict),
    .rsp_victim_tag (rsp_victim_tag),
    .tram_addr      (tram_addr),
    .tram_we        (tram_we),
    .tram_din       (tram_din),
    .tram_dout      (tram_dout),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  task automatic preload(input int idx, input logic [DW-1:0] word);
    mem[idx]     <= word;
    ref_mem[idx]  = word;
  endtask

  // One full request/response transaction, checked against the model.
  task automatic do_req(input logic [TW-1:0] tag, input logic [AW-1:0] idx,
                        input logic wr, input int hold);
    logic [DW-1:0] word;
    logic          e_hit, e_evict, e_upd;
    logic [TW-1:0] e_victim;
    logic [DW-1:0] e_new;
    int            e_lat, cyc, wait_n;
    logic          s_hit, s_evict;
    logic [TW-1:0] s_victim;

    word     = ref_mem[idx];
    e_hit    = word[DW-1] && (word[TW-1:0] == tag);
    e_evict  = !e_hit && word[DW-1] && word[DW-2];
    e_victim = e_evict ? word[TW-1:0] : '0;
    e_upd    = !e_hit || (wr && !word[DW-2]);
    e_new    = {1'b1, wr, tag};
    e_lat    = e_upd ? 4 : 3;
    if (e_hit) model_hits   = (model_hits   < 65535) ? model_hits + 1   : 65535;
    else       model_misses = (model_misses < 65535) ? model_misses + 1 : 65535;

    wait_n = 0;
    while (!req_ready && wait_n < 50) begin
      @(negedge clock);
      wait_n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_wait: req_ready=%b required 1", req_ready);
    end

    req_addr  = {tag, idx, 2'($urandom)};
    req_write = wr;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    cyc = 1;

    checks++;
    if (tram_addr !== idx) begin
      errors++;
      $display("FAIL tram_addr: got %0d required %0d", tram_addr, idx);
    end

    while (rsp_valid !== 1'b1 && cyc < 10) begin
      checks++;
      if (tram_we !== (e_upd && cyc == 3)) begin
        errors++;
        $display("FAIL tram_we cycle %0d: got %b required %b", cyc, tram_we, e_upd && cyc == 3);
      end
      if (tram_we === 1'b1) begin
        checks++;
        if (tram_din !== e_new) begin
          errors++;
          $display("FAIL tram_din: got %h required %h", tram_din, e_new);
        end
      end
      @(posedge clock);
      #1;
      cyc++;
    end

    checks++;
    if (cyc !== e_lat) begin
      errors++;
      $display("FAIL latency: rsp_valid at cycle %0d required %0d", cyc, e_lat);
    end
    checks++;
    if (rsp_hit !== e_hit || rsp_evict !== e_evict || rsp_victim_tag !== e_victim) begin
      errors++;
      $display("FAIL rsp_fields: hit=%b evict=%b victim=%h required %b %b %h",
               rsp_hit, rsp_evict, rsp_victim_tag, e_hit, e_evict, e_victim);
    end
    checks++;
    if (hit_count !== 16'(model_hits) || miss_count !== 16'(model_misses)) begin
      errors++;
      $display("FAIL counters: hit=%0d miss=%0d required %0d %0d",
               hit_count, miss_count, model_hits, model_misses);
    end

    s_hit = rsp_hit; s_evict = rsp_evict; s_victim = rsp_victim_tag;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_addr  = 17'($urandom);
      @(posedge clock);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || tram_addr !== idx ||
          rsp_hit !== s_hit || rsp_evict !== s_evict || rsp_victim_tag !== s_victim) begin
        errors++;
        $display("FAIL backpressure hold %0d: valid=%b ready=%b addr=%0d hit=%b evict=%b victim=%h",
                 k, rsp_valid, req_ready, tram_addr, rsp_hit, rsp_evict, rsp_victim_tag);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end

    if (e_upd) ref_mem[idx] = e_new;
    checks++;
    if (mem[idx] !== ref_mem[idx]) begin
      errors++;
      $display("FAIL ram_word set %0d: got %h required %h", idx, mem[idx], ref_mem[idx]);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    rsp_ready = 1'b1;
    model_hits = 0;
    model_misses = 0;
    for (int i = 0; i < 8; i++) preload(i, '0);
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || tram_we !== 1'b0 ||
        tram_din !== '0 || tram_addr !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b we=%b din=%h addr=%0d",
               req_ready, rsp_valid, tram_we, tram_din, tram_addr);
    end
    checks++;
    if (hit_count !== 16'h0 || miss_count !== 16'h0 || rsp_hit !== 1'b0 ||
        rsp_evict !== 1'b0 || rsp_victim_tag !== '0) begin
      errors++;
      $display("FAIL reset_rsp: hits=%0d misses=%0d hit=%b evict=%b victim=%h",
               hit_count, miss_count, rsp_hit, rsp_evict, rsp_victim_tag);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read_hit();
    preload(2, {1'b1, 1'b0, 12'h0AB});
    @(negedge clock);
    do_req(12'h0AB, 3'd2, 1'b0, 0);
  endtask

  task automatic test_write_hit();
    do_req(12'h0AB, 3'd2, 1'b1, 0);
  endtask

  task automatic test_evict();
    preload(5, {1'b1, 1'b1, 12'h123});
    @(negedge clock);
    do_req(12'h456, 3'd5, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    do_req(12'h777, 3'd1, 1'b1, 5);
  endtask

  task automatic test_reset_update();
    int cyc;
    req_addr  = {12'h9A5, 3'd6, 2'd0};
    req_write = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    cyc = 1;
    while (tram_we !== 1'b1 && cyc < 10) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL update_cycle: tram_we at cycle %0d required 3", cyc);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (tram_we !== 1'b0 || tram_din !== '0 || tram_addr !== '0 || rsp_valid !== 1'b0 ||
        hit_count !== 16'h0 || miss_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_in_update: we=%b din=%h addr=%0d valid=%b hits=%0d misses=%0d",
               tram_we, tram_din, tram_addr, rsp_valid, hit_count, miss_count);
    end
    model_hits = 0;
    model_misses = 0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || mem[6] !== ref_mem[6]) begin
      errors++;
      $display("FAIL after_reset: ready=%b set6=%h required 1 %h", req_ready, mem[6], ref_mem[6]);
    end
  endtask

  task automatic test_saturation();
    @(negedge clock);
    force dut.u_hit_cnt.r_count = 16'hFFFE;
    #1;
    release dut.u_hit_cnt.r_count;
    model_hits = 65534;
    for (int i = 0; i < 3; i++) do_req(12'h0AB, 3'd2, 1'b0, 0);
    checks++;
    if (hit_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturation: hit_count=%h required FFFF", hit_count);
    end
  endtask

  task automatic test_random();
    logic [TW-1:0] tags [4];
    tags[0] = 12'h0AB; tags[1] = 12'h123; tags[2] = 12'h456; tags[3] = 12'h9A5;
    for (int i = 0; i < 40; i++) begin
      logic [TW-1:0] t;
      t = ($urandom_range(0, 4) == 4) ? 12'($urandom) : tags[$urandom_range(0, 3)];
      do_req(t, 3'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_evict();
    test_backpressure();
    test_reset_update();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
